// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
//   Shared definitions for the two-port ALU arbiter and its ALU.
//   - state_e   : arbiter FSM states (IDLE, EXEC, RESP)
//   - OP_*      : 2-bit ALU opcodes, arithmetic and logic meanings
//   - DATA_W    : operand / result width
package alu_arbiter_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Arithmetic opcodes (arit = 1)
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NEGA = 2'b10;
  localparam logic [1:0] OP_NEGB = 2'b11;

  // Logic opcodes (arit = 0) share the same encodings
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu
//   Purely combinational 4-bit ALU.
//   Ports:
//     a_i, b_i   in  [3:0]  operands
//     op_i       in  [1:0]  opcode (see alu_arbiter_pkg)
//     arit_i     in         1 = arithmetic, 0 = logic
//     r_o        out [3:0]  result (mod 16)
//     zero_o     out        r_o == 0
//     carry_o    out        carry-out of bit 3 (0 for logic ops)
//     sign_o     out        r_o[3] (0 for logic ops)
//   Arithmetic: ADD = A+B, SUB = A+~B+1, NEGA = 0+~A+1, NEGB = 0+~B+1.
//   Logic:      AND, OR, XOR, NOT A.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [1:0]        op_i,
  input  logic              arit_i,
  output logic [DATA_W-1:0] r_o,
  output logic              zero_o,
  output logic              carry_o,
  output logic              sign_o
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] logicRes;

  // Subtraction and negation are done as two's-complement additions so
  // the carry flag is always the true carry-out of the adder.
  always_comb begin
    sum = '0;
    case (op_i)
      OP_ADD:  sum = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  sum = {1'b0, a_i} + {1'b0, ~b_i} + 5'd1;
      OP_NEGA: sum = {1'b0, ~a_i} + 5'd1;
      OP_NEGB: sum = {1'b0, ~b_i} + 5'd1;
    endcase
  end

  always_comb begin
    logicRes = '0;
    case (op_i)
      OP_AND:  logicRes = a_i & b_i;
      OP_OR:   logicRes = a_i | b_i;
      OP_XOR:  logicRes = a_i ^ b_i;
      OP_NOTA: logicRes = ~a_i;
    endcase
  end

  // Flags that only make sense for arithmetic are forced low otherwise.
  always_comb begin
    r_o     = arit_i ? sum[DATA_W-1:0] : logicRes;
    zero_o  = (r_o == '0);
    carry_o = arit_i & sum[DATA_W];
    sign_o  = arit_i & sum[DATA_W-1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-port arbiter in front of a single shared ALU. One request is
//   accepted in IDLE, executed in EXEC and held in RESP until consumed.
//   Parameter FIXED_PRIO: 0 = round-robin, 1 = port 0 always wins.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     req_valid  in  [1:0]  per-port request valid
//     req_ready  out [1:0]  per-port accept strobe (one-hot or zero)
//     req_a/b    in  [7:0]  operands, nibble p = port p
//     req_op     in  [3:0]  opcodes, bits [2p+1:2p] = port p
//     req_arit   in  [1:0]  per-port arithmetic/logic select
//     rsp_valid  out        result available (state RESP)
//     rsp_ready  in         consumer accepts result
//     rsp_id     out        port that issued the result
//     rsp_r      out [3:0]  result
//     rsp_zero/carry/sign   result flags
//     busy       out        state is not IDLE
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [7:0]        req_a,
  input  logic [7:0]        req_b,
  input  logic [3:0]        req_op,
  input  logic [1:0]        req_arit,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_r,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic              rsp_sign,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                lastGrant_q;
  logic [DATA_W-1:0]   opA_q, opB_q;
  logic [1:0]          op_q;
  logic                arit_q;
  logic                id_q;
  logic [DATA_W-1:0]   rspR_q;
  logic                rspZero_q, rspCarry_q, rspSign_q, rspId_q;

  logic                winner;
  logic                accept;
  logic [DATA_W-1:0]   aluR;
  logic                aluZero, aluCarry, aluSign;

  // A tie goes to port 0 in fixed mode, otherwise to the port not granted
  // last; a lone requester always wins.
  always_comb begin
    winner = req_valid[1];
    if (req_valid == 2'b11) begin
      winner = FIXED_PRIO ? 1'b0 : ~lastGrant_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          accept            = 1'b1;
          req_ready[winner] = 1'b1;
          state_d           = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are sampled only in the accept cycle; response
  // registers load from the ALU in EXEC and then hold through RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant_q <= 1'b1;
      opA_q       <= '0;
      opB_q       <= '0;
      op_q        <= '0;
      arit_q      <= 1'b0;
      id_q        <= 1'b0;
      rspR_q      <= '0;
      rspZero_q   <= 1'b0;
      rspCarry_q  <= 1'b0;
      rspSign_q   <= 1'b0;
      rspId_q     <= 1'b0;
    end else begin
      if (accept) begin
        lastGrant_q <= winner;
        id_q        <= winner;
        opA_q       <= winner ? req_a[7:4] : req_a[3:0];
        opB_q       <= winner ? req_b[7:4] : req_b[3:0];
        op_q        <= winner ? req_op[3:2] : req_op[1:0];
        arit_q      <= req_arit[winner];
      end
      if (state_q == EXEC) begin
        rspR_q     <= aluR;
        rspZero_q  <= aluZero;
        rspCarry_q <= aluCarry;
        rspSign_q  <= aluSign;
        rspId_q    <= id_q;
      end
    end
  end

  alu uAlu (
    .a_i     (opA_q),
    .b_i     (opB_q),
    .op_i    (op_q),
    .arit_i  (arit_q),
    .r_o     (aluR),
    .zero_o  (aluZero),
    .carry_o (aluCarry),
    .sign_o  (aluSign)
  );

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rspId_q;
  assign rsp_r     = rspR_q;
  assign rsp_zero  = rspZero_q;
  assign rsp_carry = rspCarry_q;
  assign rsp_sign  = rspSign_q;

endmodule
